// File: rtl/gpr_seq_pkg.sv
// rtl/gpr_seq_pkg.sv - shared opcodes, modes, states and instruction field positions
package gpr_seq_pkg;

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_READ  = 4'd1;
   localparam logic [3:0] OP_WRITE = 4'd2;
   localparam logic [3:0] OP_CLR   = 4'd3;
   localparam logic [3:0] OP_MOV   = 4'd4;
   localparam logic [3:0] OP_ALU   = 4'd5;

   localparam logic [2:0] MODE_IDLE  = 3'b000;
   localparam logic [2:0] MODE_READ  = 3'b001;
   localparam logic [2:0] MODE_WRITE = 3'b010;
   localparam logic [2:0] MODE_CLR   = 3'b011;
   localparam logic [2:0] MODE_XFER  = 3'b100;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int DST_MSB = 11;
   localparam int DST_LSB = 9;
   localparam int SRC_MSB = 8;
   localparam int SRC_LSB = 6;
   localparam int ALU_MSB = 5;
   localparam int ALU_LSB = 3;

   typedef enum logic [2:0] {
      IDLE,
      EXEC,
      HOLD,
      ALU_LOAD,
      ALU_ACC
   } state_t;

   typedef enum logic [2:0] {
      CLS_NOP,
      CLS_READ,
      CLS_WRITE,
      CLS_CLR,
      CLS_MOV,
      CLS_ALU,
      CLS_ILL
   } op_class_t;

endpackage

// File: rtl/gpr_instr_decode.sv
// rtl/gpr_instr_decode.sv - combinational split of an instruction word into control fields
module gpr_instr_decode
   import gpr_seq_pkg::*;
#(
   parameter int         INSTR_W   = 16,
   parameter logic [2:0] ALU_B_REG = 3'd1
) (
   input  logic [INSTR_W-1:0] instr,
   output op_class_t          op_class,
   output logic [2:0]         dst,
   output logic [2:0]         src,
   output logic [2:0]         alu_op,
   output logic               skip_load,
   output logic               is_illegal
);

   logic [3:0] opcode;
   logic       unused_rsvd;

   assign opcode      = instr[OPC_MSB:OPC_LSB];
   assign dst         = instr[DST_MSB:DST_LSB];
   assign src         = instr[SRC_MSB:SRC_LSB];
   assign alu_op      = instr[ALU_MSB:ALU_LSB];
   assign unused_rsvd = ^instr[ALU_LSB-1:0];

   always_comb begin
      op_class = CLS_ILL;
      case (opcode)
         OP_NOP:   op_class = CLS_NOP;
         OP_READ:  op_class = CLS_READ;
         OP_WRITE: op_class = CLS_WRITE;
         OP_CLR:   op_class = CLS_CLR;
         OP_MOV:   op_class = CLS_MOV;
         OP_ALU:   op_class = CLS_ALU;
         default:  op_class = CLS_ILL;
      endcase
   end

   // Operand already sits in the ALU B register, so the transfer step is redundant.
   assign skip_load  = (src == ALU_B_REG);
   assign is_illegal = (op_class == CLS_ILL);

endmodule

// File: rtl/gpr_sequencer.sv
// rtl/gpr_sequencer.sv - multi-cycle register-file control sequencer with retired count
module gpr_sequencer
   import gpr_seq_pkg::*;
#(
   parameter int         INSTR_W   = 16,
   parameter int         CNT_W     = 16,
   parameter logic [2:0] ALU_B_REG = 3'd1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               instr_valid,
   input  logic [INSTR_W-1:0] instr,
   output logic               instr_ready,
   output logic               gpr_enable,
   output logic [2:0]         gpr_mode,
   output logic [2:0]         gpr_src_addr,
   output logic [2:0]         gpr_dst_addr,
   output logic               alu2in_enable,
   output logic               acc_enable,
   output logic [2:0]         alu_op,
   output logic               bus_drive_req,
   output logic               bus_capture,
   output logic               done,
   output logic               illegal,
   output logic [CNT_W-1:0]   ret_count
);

   state_t     state;
   op_class_t  d_class;
   logic [2:0] d_dst, d_src, d_alu_op;
   logic       d_skip, d_illegal;
   logic       is_read_q;
   logic [2:0] alu_op_q;

   gpr_instr_decode #(.INSTR_W(INSTR_W), .ALU_B_REG(ALU_B_REG)) u_decode (
      .instr      (instr),
      .op_class   (d_class),
      .dst        (d_dst),
      .src        (d_src),
      .alu_op     (d_alu_op),
      .skip_load  (d_skip),
      .is_illegal (d_illegal)
   );

   assign instr_ready = (state == IDLE) && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         gpr_enable    <= 1'b0;
         gpr_mode      <= MODE_IDLE;
         gpr_src_addr  <= 3'd0;
         gpr_dst_addr  <= 3'd0;
         alu2in_enable <= 1'b0;
         acc_enable    <= 1'b0;
         alu_op        <= 3'd0;
         bus_drive_req <= 1'b0;
         bus_capture   <= 1'b0;
         done          <= 1'b0;
         illegal       <= 1'b0;
         ret_count     <= '0;
         is_read_q     <= 1'b0;
         alu_op_q      <= 3'd0;
      end else begin
         // Every control cycle starts from idle values; the case below only raises what it needs.
         gpr_enable    <= 1'b0;
         gpr_mode      <= MODE_IDLE;
         gpr_src_addr  <= 3'd0;
         gpr_dst_addr  <= 3'd0;
         alu2in_enable <= 1'b0;
         acc_enable    <= 1'b0;
         alu_op        <= 3'd0;
         bus_drive_req <= 1'b0;
         bus_capture   <= 1'b0;
         done          <= 1'b0;
         illegal       <= 1'b0;
         if (done)
            ret_count <= ret_count + CNT_W'(1);

         case (state)
            IDLE: if (instr_valid) begin
               is_read_q <= (d_class == CLS_READ);
               alu_op_q  <= d_alu_op;
               state     <= EXEC;
               case (d_class)
                  CLS_NOP: done <= 1'b1;
                  CLS_READ: begin
                     gpr_enable   <= 1'b1;
                     gpr_mode     <= MODE_READ;
                     gpr_src_addr <= d_src;
                  end
                  CLS_WRITE: begin
                     gpr_enable    <= 1'b1;
                     gpr_mode      <= MODE_WRITE;
                     gpr_dst_addr  <= d_dst;
                     bus_drive_req <= 1'b1;
                     done          <= 1'b1;
                  end
                  CLS_CLR: begin
                     gpr_enable   <= 1'b1;
                     gpr_mode     <= MODE_CLR;
                     gpr_dst_addr <= d_dst;
                     done         <= 1'b1;
                  end
                  CLS_MOV: begin
                     gpr_enable   <= 1'b1;
                     gpr_mode     <= MODE_XFER;
                     gpr_src_addr <= d_src;
                     gpr_dst_addr <= d_dst;
                     done         <= 1'b1;
                  end
                  CLS_ALU: if (d_skip) begin
                     state         <= ALU_ACC;
                     alu2in_enable <= 1'b1;
                     acc_enable    <= 1'b1;
                     alu_op        <= d_alu_op;
                     done          <= 1'b1;
                  end else begin
                     state        <= ALU_LOAD;
                     gpr_enable   <= 1'b1;
                     gpr_mode     <= MODE_XFER;
                     gpr_src_addr <= d_src;
                     gpr_dst_addr <= ALU_B_REG;
                  end
                  default: begin
                     illegal <= d_illegal;
                     done    <= 1'b1;
                  end
               endcase
            end
            // A read keeps the register file selected for one more cycle while it drives the bus.
            EXEC: if (is_read_q) begin
               state        <= HOLD;
               gpr_enable   <= 1'b1;
               gpr_mode     <= MODE_READ;
               gpr_src_addr <= gpr_src_addr;
               bus_capture  <= 1'b1;
               done         <= 1'b1;
            end else begin
               state <= IDLE;
            end
            HOLD: state <= IDLE;
            ALU_LOAD: begin
               state         <= ALU_ACC;
               alu2in_enable <= 1'b1;
               acc_enable    <= 1'b1;
               alu_op        <= alu_op_q;
               done          <= 1'b1;
            end
            ALU_ACC: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
